// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
package uart_pkg;

    localparam int DATA_BITS                = 8;
    localparam int CLK_PER_HALF_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Show-ahead receive FIFO. The head byte is visible on dout without a pop.
// dout reads 0 when the FIFO is empty.
// A push into a full FIFO is accepted only when it comes with a pop in the
// same cycle. Otherwise the push is dropped and reported on overflow.
module rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_BITS-1:0]  din,
    input  logic                  pop,
    output logic [DATA_BITS-1:0]  dout,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr, rptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & full & ~do_pop;
    assign count    = count_q;
    assign dout     = empty ? '0 : mem[rptr];

    // Pointers wrap naturally at the FIFO depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr <= wptr + DEPTH_LOG2'(1);
            if (do_pop)  rptr <= rptr + DEPTH_LOG2'(1);
            if (do_push && !do_pop)      count_q <= count_q + (DEPTH_LOG2+1)'(1);
            else if (!do_push && do_pop) count_q <= count_q - (DEPTH_LOG2+1)'(1);
        end
    end

    // Storage needs no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a small receive FIFO and sticky error flags.
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit
// after bit 7.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = CLK_PER_HALF_BIT_DEFAULT,
    parameter int FIFO_DEPTH_LOG2  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rxd,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [7:0]               rdata,
    output logic                     rx_ready,
    output logic [FIFO_DEPTH_LOG2:0] rx_count,
    output logic                     overrun,
    output logic                     frame_err,
    output logic                     parity_err
);

    localparam int CNT_W = $clog2(2 * CLK_PER_HALF_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_PER_HALF_BIT - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(2 * CLK_PER_HALF_BIT - 1);

    rx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 rxd_q;
    logic                 expire;
    logic                 push;
    logic                 set_frame;
    logic                 fifo_empty, fifo_full, fifo_ovf;

`ifdef UART_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    logic set_parity;
`endif

    assign expire = (cnt_q == '0);

    // State and datapath registers. Reset parks the FSM in BREAK, so a line
    // that is low when reset releases is not taken as a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= BREAK;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            rxd_q     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rxd_q     <= rxd;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic and bit timing. Each bit is sampled at mid-bit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        set_frame = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
        set_parity = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rxd && rxd_q) begin
                    state_d = START;
                    cnt_d   = HALF_LOAD;
                end
            end
            START: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rxd) begin
                    state_d = DATA;
                    cnt_d   = FULL_LOAD;
                    bit_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end else begin
                    // The line went high again before mid-start, so this was a glitch.
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    shift_d = {rxd, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL_LOAD;
                    if (bit_q == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Even parity: the data bits XORed with the parity bit must give 0.
                    par_bad_d  = (rxd != ^shift_q);
                    set_parity = (rxd != ^shift_q);
                    cnt_d      = FULL_LOAD;
                    state_d    = STOP;
                end
            end
`endif
            STOP: begin
                if (!expire) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (rxd) begin
`ifdef UART_RX_PARITY_EN
                    push = ~par_bad_q;
`else
                    push = 1'b1;
`endif
                    state_d = IDLE;
                end else begin
                    set_frame = 1'b1;
                    state_d   = BREAK;
                end
            end
            BREAK: begin
                if (rxd) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    rx_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .din      (shift_q),
        .pop      (rd_en),
        .dout     (rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (rx_count),
        .overflow (fifo_ovf)
    );

    assign rx_ready = ~fifo_empty;

    // Sticky flags. When a flag is set in the same cycle as clr_err, the set wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= (overrun & ~clr_err) | fifo_ovf;
            frame_err <= (frame_err & ~clr_err) | set_frame;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Sticky parity flag, with the same clear and set behaviour as the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= (parity_err & ~clr_err) | set_parity;
    end
`else
    assign parity_err = 1'b0;
`endif

    // fifo_full is internal only: it feeds the FIFO's own overflow decision.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLK_PER_HALF_BIT=4 (8 clocks per bit).
// A scoreboard queue holds the bytes expected to reach the FIFO.
module tb_uart_rx;

    localparam int HB    = 4;
    localparam int BIT   = 2 * HB;
    localparam int DL    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, rxd, rd_en, clr_err;
    logic [7:0]    rdata;
    logic          rx_ready;
    logic [DL:0]   rx_count;
    logic          overrun, frame_err, parity_err;

    int            n_chk = 0, n_pass = 0;
    logic [7:0]    exp_q[$];
    int            mdl_cnt = 0;
    logic          mdl_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx #(.CLK_PER_HALF_BIT(HB), .FIFO_DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
        .rdata(rdata), .rx_ready(rx_ready), .rx_count(rx_count),
        .overrun(overrun), .frame_err(frame_err), .parity_err(parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        tick(BIT);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
    endtask

    // Pop one byte. The head is checked against the scoreboard before the pop.
    task automatic pop_chk(input string tag);
        logic [7:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        chk(tag, rdata, e);
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        if (mdl_cnt > 0) mdl_cnt--;
        chk({tag, "_cnt"}, rx_count, mdl_cnt);
    endtask

    // Send a full frame. pop_mid asserts rd_en so the pop lands on the mid-stop push edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input logic par_v, input logic pop_mid);
        logic good;
        logic [7:0] h;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_v);
        good = stop_v && (par_v == ^b);
`else
        good = stop_v;
`endif
        rxd = stop_v;
        if (pop_mid) begin
            tick(HB);
            h = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            chk("mid_pop_head", rdata, h);
            rd_en = 1'b1;
            if (mdl_cnt > 0) mdl_cnt--;
            tick(1);
            rd_en = 1'b0;
            tick(HB - 1);
        end else begin
            tick(BIT);
        end
        if (good) begin
            if (mdl_cnt < DEPTH) begin
                exp_q.push_back(b);
                mdl_cnt++;
            end else begin
                mdl_ovr = 1'b1;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rxd = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        tick(3);
        chk("rst_count", rx_count, 0);
        chk("rst_ready", rx_ready, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame", frame_err, 0);
        chk("rst_parity", parity_err, 0);

        // The line stays low through reset release, so it must not start a frame.
        rst = 1'b0;
        tick(20);
        rxd = 1'b1;
        tick(10);
        chk("low_release_cnt", rx_count, 0);
        chk("low_release_frame", frame_err, 0);

        // 0xA5, checking the push latency around the mid-stop sample.
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(8'hA5 >> i);
`ifdef UART_RX_PARITY_EN
        drive_bit(^8'hA5);
`endif
        rxd = 1'b1;
        tick(HB);
        chk("a5_before_mid", rx_count, 0);
        tick(1);
        chk("a5_count", rx_count, 1);
        chk("a5_ready", rx_ready, 1);
        chk("a5_rdata", rdata, 8'hA5);
        tick(HB - 1);
        exp_q.push_back(8'hA5);
        mdl_cnt = 1;
        pop_chk("a5_pop");
        chk("a5_empty_rdata", rdata, 0);
        chk("a5_empty_ready", rx_ready, 0);

        // A pop while empty is ignored.
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        chk("empty_pop_cnt", rx_count, 0);

        // Five bytes with no reads: the fifth one overruns the FIFO.
        for (int v = 1; v <= 5; v++) send_frame(8'(v), 1'b1, ^8'(v), 1'b0);
        tick(2);
        chk("ovr_count", rx_count, mdl_cnt);
        chk("ovr_flag", overrun, mdl_ovr);
        for (int k = 0; k < 4; k++) pop_chk("ovr_pop");
        pulse_clr();
        mdl_ovr = 1'b0;
        chk("ovr_clr", overrun, 0);

        // With the FIFO full, the fifth byte's push coincides with a pop.
        send_frame(8'h10, 1'b1, ^8'h10, 1'b0);
        send_frame(8'h20, 1'b1, ^8'h20, 1'b0);
        send_frame(8'h30, 1'b1, ^8'h30, 1'b0);
        send_frame(8'h40, 1'b1, ^8'h40, 1'b0);
        chk("full_count", rx_count, 4);
        send_frame(8'h50, 1'b1, ^8'h50, 1'b1);
        chk("simul_count", rx_count, mdl_cnt);
        chk("simul_overrun", overrun, 0);
        chk("simul_head", rdata, 8'h20);
        for (int k = 0; k < 4; k++) pop_chk("simul_pop");

        // Stop bit low followed by a held break.
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
        tick(40);
        chk("brk_frame", frame_err, 1);
        chk("brk_count", rx_count, 0);
        rxd = 1'b1;
        tick(4);
        chk("brk_release_cnt", rx_count, 0);
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b0);
        pop_chk("brk_recover");
        pulse_clr();
        chk("frame_clr", frame_err, 0);

        // A 3-cycle glitch is rejected at mid-start.
        rxd = 1'b0;
        tick(3);
        rxd = 1'b1;
        tick(20);
        chk("glitch_cnt", rx_count, 0);
        chk("glitch_frame", frame_err, 0);
        chk("glitch_ovr", overrun, 0);
        send_frame(8'hC3, 1'b1, ^8'hC3, 1'b0);
        pop_chk("glitch_recover");

        // Reset in the middle of a frame abandons it.
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1;
        tick(2);
        rxd = 1'b1;
        rst = 1'b0;
        tick(10);
        chk("midrst_cnt", rx_count, 0);
        chk("midrst_frame", frame_err, 0);
        send_frame(8'h81, 1'b1, ^8'h81, 1'b0);
        pop_chk("midrst_recover");

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight, so a parity bit of 0 is a mismatch.
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        chk("par_err", parity_err, 1);
        chk("par_drop", rx_count, 0);
        pulse_clr();
        chk("par_clr", parity_err, 0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        pop_chk("par_good");
`else
        chk("par_tied", parity_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_PER_HALF_BIT, default 434, clock cycles per half bit period (one bit = 2*CLK_PER_HALF_BIT cycles).
REQ-002 SHALL have parameter FIFO_DEPTH_LOG2, default 2, giving a receive FIFO of 2**FIFO_DEPTH_LOG2 bytes.
REQ-003 clk  input  1  single clock; all state is on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 rxd  input  1  serial line; idle high; 8N1, LSB first.
REQ-006 rd_en  input  1  pops the FIFO head on this cycle.
REQ-007 clr_err  input  1  clears the sticky error flags.
REQ-008 rdata  output  8  FIFO head byte (show-ahead); 0 when the FIFO is empty.
REQ-009 rx_ready  output  1  FIFO is non-empty.
REQ-010 rx_count  output  FIFO_DEPTH_LOG2+1  number of bytes held.
REQ-011 overrun  output  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-012 frame_err  output  1  sticky flag: the stop bit was sampled low.
REQ-013 parity_err  output  1  sticky flag: a parity mismatch occurred (see Configuration).

Function
REQ-014 The FSM SHALL have these states: IDLE, START, DATA, PARITY, STOP, BREAK.
REQ-015 In IDLE, when rxd is 0 and its registered previous value is 1, the FSM SHALL enter START and load the bit counter with CLK_PER_HALF_BIT-1.
REQ-016 At START counter expiry (mid start bit):
- rxd=0: go to DATA and load 2*CLK_PER_HALF_BIT-1.
- rxd=1: treat as a glitch and return to IDLE; nothing is pushed and no flag changes.
REQ-017 In DATA, the FSM SHALL sample rxd at each counter expiry into shift bit 0..7 (LSB first) and reload the counter. After bit 7 it goes to STOP, or to PARITY when parity is enabled.
REQ-018 At STOP expiry (mid stop bit):
- rxd=1: push the byte and go to IDLE.
- rxd=0: set frame_err, discard the byte, go to BREAK.
REQ-019 BREAK SHALL remain until rxd=1, then go to IDLE; no start bit is detected while in BREAK.
REQ-020 Latency: rx_ready and rx_count SHALL update on the cycle after the mid-stop sample.
REQ-021 A push into a full FIFO without a same-cycle pop SHALL drop the byte, set overrun, and leave the contents unchanged.
REQ-022 Push and pop in the same cycle when full SHALL accept both; rx_count is unchanged and overrun is not set.
REQ-023 rd_en while empty SHALL be ignored; rx_count does not underflow.
REQ-024 Read and write pointers SHALL wrap modulo the FIFO depth; rx_count saturates at the FIFO depth.
REQ-025 A clr_err pulse SHALL clear all sticky flags on the next cycle. A flag set in the same cycle as clr_err remains set (set wins).

Reset
REQ-026 While rst=1, the block SHALL hold:
- FSM = BREAK, so a line held low at reset release is not taken as a start bit;
- FIFO empty: rdata=0, rx_ready=0, rx_count=0;
- overrun=0, frame_err=0, parity_err=0.
REQ-027 rst asserted mid-frame SHALL abandon the frame with no push and no flag set.

Configuration
REQ-028 With UART_RX_PARITY_EN defined:
- one even-parity bit follows bit 7, sampled in PARITY at one full bit period;
- on mismatch, parity_err is set and the byte is discarded; the stop-bit check still runs.
REQ-029 Without UART_RX_PARITY_EN: the PARITY state is never entered and parity_err is tied to 0.

Structure
REQ-030 Package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, and the default CLK_PER_HALF_BIT.
REQ-031 The FIFO SHALL be a sub-module, rx_fifo (push/pop/full/empty/count), instantiated once.

Verification (CLK_PER_HALF_BIT=4)
REQ-032 Send 0xA5 in 8N1 -> at the cycle after mid-stop: rx_ready=1, rdata=0xA5, rx_count=1; pulse rd_en -> rx_count=0, rdata=0.
REQ-033 Send 0x01,0x02,0x03,0x04,0x05 with no reads -> rx_count=4, overrun=1, pops return 0x01..0x04.
REQ-034 Send 0x3C with stop bit low, then hold rxd low 40 cycles -> frame_err=1, nothing pushed, no new frame until rxd returns high.
REQ-035 Drive a 3-cycle low glitch on rxd -> state returns to IDLE, rx_count=0, no flag set.
REQ-036 FIFO full, and a fifth byte finishes on the same cycle as rd_en -> rx_count stays 4, overrun=0, head advances.
REQ-037 UART_RX_PARITY_EN defined, 0x07 sent with parity bit 0 -> parity_err=1, byte dropped; clr_err -> parity_err=0.
